// File: rtl/operand_fetch.sv
// operand_fetch: latches a decoded instruction, reads its source operands
// from a two-port register file (A read/write, B read-only) and presents the
// operands to the execute stage. Registers 14 and 15 are pop-on-read stacks,
// so every read is issued exactly once. Same-stack A/B reads are split into
// two ordered pops. Write-backs take priority over reads on port A.
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [3:0]  in_a_sel,
    input  logic [3:0]  in_b_sel,
    input  logic [3:0]  in_dst,
    input  logic        in_use_a,
    input  logic        in_use_b,
    input  logic        in_use_imm,
    input  logic [15:0] in_imm,

    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  wb_sel,
    input  logic [15:0] wb_data,

    output logic [3:0]  rf_a_sel,
    output logic [3:0]  rf_b_sel,
    output logic        rf_a_rd_en,
    output logic        rf_b_rd_en,
    output logic        rf_a_wr_en,
    output logic [15:0] rf_a_wr_data,
    input  logic [15:0] rf_a_rd_data,
    input  logic [15:0] rf_b_rd_data,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [3:0]  out_dst,
    output logic [15:0] out_a,
    output logic [15:0] out_b
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAP     = 3'd2,
        ISSUE_B = 3'd3,
        CAP_B   = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t      state;

    // Latched instruction fields
    logic [3:0]  a_sel_q;
    logic [3:0]  b_sel_q;
    logic        use_a_q;
    logic        rd_b_q;     // B is read from the register file in the first pass
    logic        use_imm_q;
    logic        split_q;    // B pop deferred to ISSUE_B after the A pop
    logic [15:0] imm_q;

    logic        accept;
    logic        wb_write;
    logic        b_need;
    logic        split_in;

    // Decode of the incoming instruction's B-operand source and stack split
    always_comb begin
        b_need   = in_use_b & ~in_use_imm;
        split_in = in_use_a & b_need & (in_a_sel == in_b_sel) & (in_a_sel[3:1] == 3'b111);
    end

    // Handshakes and register-file port control
    always_comb begin
        in_ready   = (state == IDLE) | ((state == HOLD) & out_ready);
        accept     = in_valid & in_ready;
        wb_ready   = (state == IDLE) | (state == HOLD) |
                     (state == ISSUE) | (state == ISSUE_B);
        // rst_n gate keeps the write strobe quiet while reset is held, even
        // though wb_ready reads as 1 in the reset state.
        wb_write   = wb_valid & wb_ready & rst_n;

        rf_a_wr_en   = wb_write;
        rf_a_wr_data = wb_data;
        rf_a_sel     = wb_write ? wb_sel : a_sel_q;
        rf_b_sel     = b_sel_q;

        rf_a_rd_en = (state == ISSUE) & ~wb_valid & use_a_q;
        rf_b_rd_en = ((state == ISSUE) & ~wb_valid & rd_b_q) |
                     ((state == ISSUE_B) & ~wb_valid);

        out_valid  = (state == HOLD);
    end

    // Instruction latch, operand capture and state sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sel_q   <= '0;
            b_sel_q   <= '0;
            use_a_q   <= 1'b0;
            rd_b_q    <= 1'b0;
            use_imm_q <= 1'b0;
            split_q   <= 1'b0;
            imm_q     <= '0;
            out_op    <= '0;
            out_dst   <= '0;
            out_a     <= '0;
            out_b     <= '0;
        end else begin
            if (accept) begin
                a_sel_q   <= in_a_sel;
                b_sel_q   <= in_b_sel;
                use_a_q   <= in_use_a;
                rd_b_q    <= b_need & ~split_in;
                use_imm_q <= in_use_imm;
                split_q   <= split_in;
                imm_q     <= in_imm;
                out_op    <= in_op;
                out_dst   <= in_dst;
            end

            case (state)
                IDLE: begin
                    if (in_valid) state <= ISSUE;
                end
                ISSUE: begin
                    if (!wb_valid) state <= CAP;
                end
                CAP: begin
                    out_a <= use_a_q ? rf_a_rd_data : '0;
                    if (use_imm_q)   out_b <= imm_q;
                    else if (rd_b_q) out_b <= rf_b_rd_data;
                    else             out_b <= '0;
                    state <= split_q ? ISSUE_B : HOLD;
                end
                ISSUE_B: begin
                    if (!wb_valid) state <= CAP_B;
                end
                CAP_B: begin
                    out_b <= rf_b_rd_data;
                    state <= HOLD;
                end
                HOLD: begin
                    if (out_ready) state <= in_valid ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port A never reads and writes in the same cycle
    a_port_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(rf_a_rd_en && rf_a_wr_en));

    // Reads are issued only from the two issue states
    read_only_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
        (rf_a_rd_en || rf_b_rd_en) |-> (state == ISSUE || state == ISSUE_B));

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file whose
// registers 14 and 15 are pop-on-read / push-on-write stacks.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_op, in_a_sel, in_b_sel, in_dst;
    logic        in_use_a, in_use_b, in_use_imm;
    logic [15:0] in_imm;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_sel;
    logic [15:0] wb_data;
    logic [3:0]  rf_a_sel, rf_b_sel;
    logic        rf_a_rd_en, rf_b_rd_en, rf_a_wr_en;
    logic [15:0] rf_a_wr_data;
    logic [15:0] rf_a_rd_data, rf_b_rd_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_op, out_dst;
    logic [15:0] out_a, out_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_dst(in_dst),
        .in_use_a(in_use_a), .in_use_b(in_use_b), .in_use_imm(in_use_imm),
        .in_imm(in_imm),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sel(wb_sel), .wb_data(wb_data),
        .rf_a_sel(rf_a_sel), .rf_b_sel(rf_b_sel),
        .rf_a_rd_en(rf_a_rd_en), .rf_b_rd_en(rf_b_rd_en), .rf_a_wr_en(rf_a_wr_en),
        .rf_a_wr_data(rf_a_wr_data),
        .rf_a_rd_data(rf_a_rd_data), .rf_b_rd_data(rf_b_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_dst(out_dst), .out_a(out_a), .out_b(out_b)
    );

    // ---------------- register file model ----------------
    logic [15:0] regs [0:13];
    logic [15:0] stk  [0:1][0:7];
    int          sp   [0:1];
    int rda_cnt = 0, rdb_cnt = 0, wr_cnt = 0, pop_cnt = 0, both_cnt = 0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_sel = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] va, vb;

    task automatic rf_read(input logic [3:0] sel, output logic [15:0] v);
        int s;
        s = int'(sel) - 14;
        if (sel >= 4'd14) begin
            if (sp[s] > 0) begin
                sp[s] = sp[s] - 1;
                v = stk[s][sp[s]];
                pop_cnt++;
            end else begin
                v = 16'hDEAD;
            end
        end else begin
            v = regs[int'(sel)];
        end
    endtask

    task automatic rf_write(input logic [3:0] sel, input logic [15:0] d);
        int s;
        s = int'(sel) - 14;
        if (sel >= 4'd14) begin
            if (sp[s] < 8) begin
                stk[s][sp[s]] = d;
                sp[s] = sp[s] + 1;
            end
        end else begin
            regs[int'(sel)] = d;
        end
    endtask

    always @(posedge clk) begin
        if (ld_en) rf_write(ld_sel, ld_data);
        if (rf_a_wr_en) begin
            wr_cnt++;
            rf_write(rf_a_sel, rf_a_wr_data);
        end
        if (rf_a_rd_en) begin
            rda_cnt++;
            rf_read(rf_a_sel, va);
            rf_a_rd_data <= va;
        end
        if (rf_b_rd_en) begin
            rdb_cnt++;
            rf_read(rf_b_sel, vb);
            rf_b_rd_data <= vb;
        end
        if (rf_a_rd_en && rf_b_rd_en) both_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input logic [3:0] sel, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = sel; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Caller must be at a negedge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] dst, input logic ua, input logic ub,
                         input logic ui, input logic [15:0] imm);
        int n;
        in_op = op; in_a_sel = a; in_b_sel = b; in_dst = dst;
        in_use_a = ua; in_use_b = ub; in_use_imm = ui; in_imm = imm;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        @(negedge clk);
        n++;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        wb_valid = 1'b1; wb_sel = 4'd3; wb_data = 16'h7777;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({out_valid, in_ready, wb_ready, rf_a_rd_en, rf_b_rd_en, rf_a_wr_en} !== 6'b011000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=011000",
                     {out_valid, in_ready, wb_ready, rf_a_rd_en, rf_b_rd_en, rf_a_wr_en});
        end
        total++;
        if ({out_op, out_dst, out_a, out_b} !== 40'h0) begin
            bad++;
            $display("FAIL reset_data got=%h required=0", {out_op, out_dst, out_a, out_b});
        end
        wb_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n, ra, rb;
        preload(4'd2, 16'h1234);
        preload(4'd5, 16'hBEEF);
        out_ready = 1'b1;
        ra = rda_cnt; rb = rdb_cnt;
        @(negedge clk);
        issue(4'd3, 4'd2, 4'd5, 4'd7, 1'b1, 1'b1, 1'b0, 16'h0);
        wait_out(n);
        total++;
        if (n !== 3) begin bad++; $display("FAIL basic_latency got=%0d required=3", n); end
        total++;
        if ({out_op, out_dst} !== {4'd3, 4'd7}) begin
            bad++; $display("FAIL basic_opdst got=%h required=37", {out_op, out_dst});
        end
        total++;
        if ({out_a, out_b} !== {16'h1234, 16'hBEEF}) begin
            bad++; $display("FAIL basic_operands got=%h required=1234beef", {out_a, out_b});
        end
        total++;
        if ((rda_cnt - ra) != 1 || (rdb_cnt - rb) != 1) begin
            bad++; $display("FAIL basic_rd_count got=%0d/%0d required=1/1", rda_cnt - ra, rdb_cnt - rb);
        end
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL basic_to_idle got=%b required=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_stack_split();
        int n, ra, rb, pc, bc;
        preload(4'd15, 16'h0022);
        preload(4'd15, 16'h0011);
        ra = rda_cnt; rb = rdb_cnt; pc = pop_cnt; bc = both_cnt;
        @(negedge clk);
        issue(4'd1, 4'd15, 4'd15, 4'd2, 1'b1, 1'b1, 1'b0, 16'h0);
        wait_out(n);
        total++;
        if (n !== 5) begin bad++; $display("FAIL split_latency got=%0d required=5", n); end
        total++;
        if ({out_a, out_b} !== {16'h0011, 16'h0022}) begin
            bad++; $display("FAIL split_operands got=%h required=00110022", {out_a, out_b});
        end
        total++;
        if ((rda_cnt - ra) != 1 || (rdb_cnt - rb) != 1 || (both_cnt - bc) != 0) begin
            bad++; $display("FAIL split_rd_pattern got=%0d/%0d/%0d required=1/1/0",
                            rda_cnt - ra, rdb_cnt - rb, both_cnt - bc);
        end
        total++;
        if ((pop_cnt - pc) != 2) begin
            bad++; $display("FAIL split_pops got=%0d required=2", pop_cnt - pc);
        end
        @(negedge clk);
    endtask

    task automatic test_imm();
        int n, rb, pc;
        preload(4'd14, 16'h0ABC);
        rb = rdb_cnt; pc = pop_cnt;
        @(negedge clk);
        issue(4'd6, 4'd14, 4'd3, 4'd4, 1'b1, 1'b1, 1'b1, 16'h8000);
        wait_out(n);
        total++;
        if ({out_a, out_b} !== {16'h0ABC, 16'h8000}) begin
            bad++; $display("FAIL imm_operands got=%h required=0abc8000", {out_a, out_b});
        end
        total++;
        if ((rdb_cnt - rb) != 0 || (pop_cnt - pc) != 1) begin
            bad++; $display("FAIL imm_reads got=%0d/%0d required=0/1", rdb_cnt - rb, pop_cnt - pc);
        end
        @(negedge clk);
    endtask

    task automatic test_wb_idle();
        int n;
        @(negedge clk);
        wb_valid = 1'b1; wb_sel = 4'd9; wb_data = 16'h0F0F;
        #1;
        total++;
        if ({wb_ready, rf_a_wr_en, rf_a_rd_en, rf_b_rd_en, rf_a_sel} !== {4'b1100, 4'd9}) begin
            bad++; $display("FAIL wb_idle_ctrl got=%b required=11001001",
                            {wb_ready, rf_a_wr_en, rf_a_rd_en, rf_b_rd_en, rf_a_sel});
        end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        issue(4'd2, 4'd9, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0);
        wait_out(n);
        total++;
        if ({out_a, out_b} !== {16'h0F0F, 16'h0000}) begin
            bad++; $display("FAIL wb_idle_read got=%h required=0f0f0000", {out_a, out_b});
        end
        @(negedge clk);
    endtask

    task automatic test_wb_priority();
        int n, wr, ra;
        wr = wr_cnt; ra = rda_cnt;
        @(negedge clk);
        issue(4'd5, 4'd2, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0);
        wb_valid = 1'b1; wb_sel = 4'd2; wb_data = 16'h5555;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({wb_ready, rf_a_wr_en, rf_a_rd_en, rf_b_rd_en, rf_a_sel, rf_a_wr_data}
                !== {4'b1100, 4'd2, 16'h5555}) begin
                bad++; $display("FAIL wbpri_write_cycle%0d got=%h required=c25555", c,
                                {wb_ready, rf_a_wr_en, rf_a_rd_en, rf_b_rd_en, rf_a_sel, rf_a_wr_data});
            end
            @(posedge clk);
        end
        #1;
        wb_valid = 1'b0;
        #1;
        total++;
        if ({wb_ready, rf_a_wr_en, rf_a_rd_en, rf_b_rd_en, rf_a_sel} !== {4'b1010, 4'd2}) begin
            bad++; $display("FAIL wbpri_read_cycle got=%b required=10100010",
                            {wb_ready, rf_a_wr_en, rf_a_rd_en, rf_b_rd_en, rf_a_sel});
        end
        wait_out(n);
        total++;
        if (out_a !== 16'h5555) begin
            bad++; $display("FAIL wbpri_out_a got=%h required=5555", out_a);
        end
        total++;
        if ((wr_cnt - wr) != 2 || (rda_cnt - ra) != 1) begin
            bad++; $display("FAIL wbpri_counts got=%0d/%0d required=2/1", wr_cnt - wr, rda_cnt - ra);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, ra, rb;
        out_ready = 1'b0;
        @(negedge clk);
        issue(4'd7, 4'd2, 4'd5, 4'd8, 1'b1, 1'b1, 1'b0, 16'h0);
        wait_out(n);
        total++;
        if (n !== 3) begin bad++; $display("FAIL stall_latency got=%0d required=3", n); end
        ra = rda_cnt; rb = rdb_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({out_valid, out_op, out_dst, out_a, out_b} !== {1'b1, 4'd7, 4'd8, 16'h5555, 16'hBEEF}) begin
                bad++; $display("FAIL stall_hold_cycle%0d got=%h required=1785555beef", c,
                                {out_valid, out_op, out_dst, out_a, out_b});
            end
        end
        total++;
        if ((rda_cnt - ra) != 0 || (rdb_cnt - rb) != 0) begin
            bad++; $display("FAIL stall_no_reads got=%0d/%0d required=0/0", rda_cnt - ra, rdb_cnt - rb);
        end
        out_ready = 1'b1;
        issue(4'd9, 4'd5, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0);
        total++;
        if ({in_ready, out_valid} !== 2'b00) begin
            bad++; $display("FAIL b2b_first_no_idle got=%b required=00", {in_ready, out_valid});
        end
        wait_out(n);
        total++;
        if (n !== 3 || out_a !== 16'hBEEF || out_op !== 4'd9) begin
            bad++; $display("FAIL b2b_first n=%0d out_a=%h op=%h required 3/beef/9", n, out_a, out_op);
        end
        issue(4'hA, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 16'h0042);
        total++;
        if ({in_ready, out_valid} !== 2'b00) begin
            bad++; $display("FAIL b2b_second_no_idle got=%b required=00", {in_ready, out_valid});
        end
        wait_out(n);
        total++;
        if (n !== 3 || {out_op, out_a, out_b} !== {4'hA, 16'h0000, 16'h0042}) begin
            bad++; $display("FAIL b2b_second n=%0d got=%h required 3/a00000042", n, {out_op, out_a, out_b});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n, rb, pc;
        preload(4'd15, 16'h0202);
        preload(4'd15, 16'h0101);
        rb = rdb_cnt; pc = pop_cnt;
        @(negedge clk);
        issue(4'hC, 4'd15, 4'd15, 4'hD, 1'b1, 1'b1, 1'b0, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready, wb_ready, rf_a_rd_en, rf_b_rd_en, rf_a_wr_en} !== 6'b011000) begin
            bad++; $display("FAIL rstmid_ctrl got=%b required=011000",
                            {out_valid, in_ready, wb_ready, rf_a_rd_en, rf_b_rd_en, rf_a_wr_en});
        end
        total++;
        if ({out_op, out_dst, out_a, out_b} !== 40'h0) begin
            bad++; $display("FAIL rstmid_data got=%h required=0", {out_op, out_dst, out_a, out_b});
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ((rdb_cnt - rb) != 0 || (pop_cnt - pc) != 1) begin
            bad++; $display("FAIL rstmid_reads got=%0d/%0d required=0/1", rdb_cnt - rb, pop_cnt - pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(4'd4, 4'd2, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 16'h0);
        wait_out(n);
        total++;
        if (n !== 3 || {out_op, out_dst, out_a, out_b} !== {4'd4, 4'd6, 16'h5555, 16'hBEEF}) begin
            bad++; $display("FAIL rstmid_recover n=%0d got=%h required 3/465555beef", n,
                            {out_op, out_dst, out_a, out_b});
        end
        @(negedge clk);
        issue(4'd1, 4'd15, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0);
        wait_out(n);
        total++;
        if (out_a !== 16'h0202) begin
            bad++; $display("FAIL rstmid_stack_left got=%h required=0202", out_a);
        end
        @(negedge clk);
    endtask

    initial begin
        sp[0] = 0; sp[1] = 0;
        for (int i = 0; i < 14; i++) regs[i] = '0;
        rf_a_rd_data = '0; rf_b_rd_data = '0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = '0; in_a_sel = '0; in_b_sel = '0; in_dst = '0;
        in_use_a = 1'b0; in_use_b = 1'b0; in_use_imm = 1'b0; in_imm = '0;
        wb_valid = 1'b0; wb_sel = '0; wb_data = '0;
        out_ready = 1'b1;

        test_reset();
        test_basic();
        test_stack_split();
        test_imm();
        test_wb_idle();
        test_wb_priority();
        test_back_to_back();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
